// File: rtl/snk_sync_gen.sv
`default_nettype none
// ============================================================================
// snk_sync_gen : raster blanking/sync/DE decode, sprite line-buffer bank,
//                vertical-blank IRQ with ack, and counter continuity check
// Rev 1.0
// ============================================================================
module snk_sync_gen #(
  parameter int H_TOTAL     = 384,
  parameter int V_TOTAL     = 264,
  parameter int H_ACTIVE    = 256,
  parameter int HS_START    = 280,
  parameter int HS_END      = 312,
  parameter int V_ACT_START = 16,
  parameter int V_ACT_END   = 240,
  parameter int VS_START    = 248,
  parameter int VS_END      = 251
) (
  input  logic       CLK_IN,
  input  logic       nRESET,
  input  logic       PIX_CE,
  input  logic [8:0] H_CNT,
  input  logic [8:0] V_CNT,
  input  logic       IRQ_ACK,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC_n,
  output logic       VSYNC_n,
  output logic       DE,
  output logic       LINE_START,
  output logic       LB_BANK,
  output logic       VBL_IRQ_n,
  output logic       IRQ_OVR,
  output logic [7:0] FRAME,
  output logic       COUNT_ERR
);

  localparam logic [8:0] c_H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] c_V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] c_H_ACTIVE  = 9'(H_ACTIVE);
  localparam logic [8:0] c_HS_START  = 9'(HS_START);
  localparam logic [8:0] c_HS_END    = 9'(HS_END);
  localparam logic [8:0] c_VA_START  = 9'(V_ACT_START);
  localparam logic [8:0] c_VA_END    = 9'(V_ACT_END);
  localparam logic [8:0] c_VS_START  = 9'(VS_START);
  localparam logic [8:0] c_VS_END    = 9'(VS_END);

  logic       w_hblank;
  logic       w_vblank;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_line_ev;
  logic       w_frame_ev;
  logic [8:0] w_exp_h;
  logic [8:0] w_exp_v;
  logic       w_cnt_bad;

  logic [8:0] r_prev_h;
  logic [8:0] r_prev_v;
  logic       r_prev_valid;

  always_comb begin
    w_hblank   = (H_CNT >= c_H_ACTIVE);
    w_vblank   = !((V_CNT >= c_VA_START) && (V_CNT < c_VA_END));
    w_hsync_n  = !((H_CNT >= c_HS_START) && (H_CNT < c_HS_END));
    w_vsync_n  = !((V_CNT >= c_VS_START) && (V_CNT < c_VS_END));
    w_line_ev  = PIX_CE && (H_CNT == 9'd0);
    w_frame_ev = w_line_ev && (V_CNT == c_VA_END);

    // Successor of the previous sample; the full H/V wrap is a legal step.
    w_exp_h = (r_prev_h == c_H_LAST) ? 9'd0 : r_prev_h + 9'd1;
    if (r_prev_h == c_H_LAST) begin
      w_exp_v = (r_prev_v == c_V_LAST) ? 9'd0 : r_prev_v + 9'd1;
    end else begin
      w_exp_v = r_prev_v;
    end
    w_cnt_bad = r_prev_valid && ((H_CNT != w_exp_h) || (V_CNT != w_exp_v));
  end

  always_ff @(posedge CLK_IN) begin
    if (!nRESET) begin
      HBLANK       <= 1'b1;
      VBLANK       <= 1'b1;
      HSYNC_n      <= 1'b1;
      VSYNC_n      <= 1'b1;
      DE           <= 1'b0;
      LINE_START   <= 1'b0;
      LB_BANK      <= 1'b0;
      VBL_IRQ_n    <= 1'b1;
      IRQ_OVR      <= 1'b0;
      FRAME        <= 8'd0;
      COUNT_ERR    <= 1'b0;
      r_prev_h     <= 9'd0;
      r_prev_v     <= 9'd0;
      r_prev_valid <= 1'b0;
    end else begin
      LINE_START <= w_line_ev;

      if (PIX_CE) begin
        HBLANK       <= w_hblank;
        VBLANK       <= w_vblank;
        HSYNC_n      <= w_hsync_n;
        VSYNC_n      <= w_vsync_n;
        DE           <= !w_hblank && !w_vblank;
        r_prev_h     <= H_CNT;
        r_prev_v     <= V_CNT;
        r_prev_valid <= 1'b1;
        if (w_cnt_bad) begin
          COUNT_ERR <= 1'b1;
        end
      end

      if (w_line_ev) begin
        LB_BANK <= ~LB_BANK;
      end

      // A new frame event beats a simultaneous ack; that ack also
      // suppresses the overrun flag for this edge.
      if (w_frame_ev) begin
        FRAME     <= FRAME + 8'd1;
        VBL_IRQ_n <= 1'b0;
        if (!VBL_IRQ_n && !IRQ_ACK) begin
          IRQ_OVR <= 1'b1;
        end
      end else if (IRQ_ACK) begin
        VBL_IRQ_n <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/snk_sync_gen.md
# snk_sync_gen

Raster decode stage sitting directly downstream of the pixel/line counter generator. It consumes the horizontal and vertical counter values plus a pixel clock enable. It produces registered blanking, sync and display-enable signals, a per-line sprite line-buffer bank toggle, and the vertical-blank interrupt to the 68000 with an acknowledge handshake. It also checks that the incoming counters advance monotonically and flags any discontinuity.

## Interface

Parameters:
- H_TOTAL, 384, pixels per line; H_CNT range 0..H_TOTAL-1
- V_TOTAL, 264, lines per frame; V_CNT range 0..V_TOTAL-1
- H_ACTIVE, 256, first blanked pixel; active pixels are 0..H_ACTIVE-1
- HS_START, 280, first H_CNT with HSYNC_n low
- HS_END, 312, first H_CNT with HSYNC_n high again
- V_ACT_START, 16, first active line
- V_ACT_END, 240, first blanked line; also the IRQ line
- VS_START, 248, first V_CNT with VSYNC_n low
- VS_END, 251, first V_CNT with VSYNC_n high again

Ports:
- CLK_IN  in  1  system clock; single clock domain
- nRESET  in  1  synchronous, active-low reset, sampled on CLK_IN rising edge
- PIX_CE  in  1  pixel clock enable; one CLK_IN cycle wide
- H_CNT  in  9  horizontal counter from the upstream counter stage
- V_CNT  in  9  vertical counter from the upstream counter stage
- IRQ_ACK  in  1  interrupt acknowledge from the 68k glue; level, CLK_IN domain
- HBLANK  out  1  high outside H_CNT 0..H_ACTIVE-1
- VBLANK  out  1  high outside V_CNT V_ACT_START..V_ACT_END-1
- HSYNC_n  out  1  low for HS_START <= H_CNT < HS_END
- VSYNC_n  out  1  low for VS_START <= V_CNT < VS_END
- DE  out  1  ~HBLANK & ~VBLANK
- LINE_START  out  1  one-cycle pulse at the start of each line
- LB_BANK  out  1  sprite line-buffer bank select; toggles every line
- VBL_IRQ_n  out  1  vertical-blank interrupt, active low, held until acknowledged
- IRQ_OVR  out  1  sticky flag: a new IRQ event arrived while the previous one was still pending
- FRAME  out  8  frame counter
- COUNT_ERR  out  1  sticky flag: counter discontinuity detected

## Operation

- All decode is registered. On a CLK_IN rising edge with PIX_CE=1, HBLANK, VBLANK, HSYNC_n, VSYNC_n and DE load the decode of the H_CNT/V_CNT sampled at that edge. Outputs hold while PIX_CE=0.
- Comparisons are unsigned and 9 bits wide. Every range is start-inclusive and end-exclusive.
- Line event: PIX_CE=1 and H_CNT==0.
  - LINE_START is high for exactly the one following cycle.
  - LB_BANK inverts at the same edge.
- Frame event: PIX_CE=1 and H_CNT==0 and V_CNT==V_ACT_END.
  - FRAME increments, wrapping 255 -> 0.
  - VBL_IRQ_n goes low.
  - If VBL_IRQ_n is already low, IRQ_OVR is set.
- IRQ_ACK=1 drives VBL_IRQ_n high on the next edge.
  - If a frame event and IRQ_ACK occur on the same edge, the set wins: VBL_IRQ_n stays or goes low. IRQ_OVR is not set by that edge.
- Continuity check, on each PIX_CE after the first one following reset:
  - Expected H = (prev_H == H_TOTAL-1) ? 0 : prev_H+1.
  - Expected V = prev_V+1 (or 0 if prev_V == V_TOTAL-1) when prev_H == H_TOTAL-1; otherwise prev_V.
  - Any mismatch sets COUNT_ERR.
  - prev_H/prev_V load on every PIX_CE.
  - A valid flag, cleared by reset, suppresses the check on the first PIX_CE.
- IRQ_OVR and COUNT_ERR are cleared only by reset.

## Timing

- Reset values (nRESET=0 at an edge):
  - HBLANK=1, VBLANK=1, HSYNC_n=1, VSYNC_n=1, DE=0
  - LINE_START=0, LB_BANK=0, VBL_IRQ_n=1
  - IRQ_OVR=0, FRAME=0, COUNT_ERR=0
  - prev-valid flag=0
- Reset overrides PIX_CE and IRQ_ACK on the same edge.
- Reset asserted mid-line or mid-IRQ returns all outputs to the reset values on that edge. The first PIX_CE after release performs decode but no continuity check.
- Latency: one CLK_IN cycle from the sampling PIX_CE edge to the output change. There is no further pipeline.
- LINE_START is exactly one CLK_IN cycle wide, independent of the PIX_CE rate. PIX_CE on consecutive cycles is legal.
- IRQ_ACK with no IRQ pending has no effect.
- Wrap-around: H_CNT H_TOTAL-1 -> 0 together with V_CNT V_TOTAL-1 -> 0 is a legal advance and does not set COUNT_ERR.

## Test plan

- Reset, then drive 2 full frames of legal counters with PIX_CE every 2nd cycle:
  - HSYNC_n low for exactly 32 PIX_CE per line.
  - VSYNC_n low for 3 lines.
  - DE high for 256 pixels × 224 lines.
  - FRAME=2 and COUNT_ERR=0 at the end.
- Frame event, then IRQ_ACK 5 cycles later:
  - VBL_IRQ_n low on the cycle after the frame event.
  - VBL_IRQ_n high the cycle after the ack.
  - IRQ_OVR=0.
- Run 2 frames with no IRQ_ACK:
  - VBL_IRQ_n stays low.
  - IRQ_OVR=1 after the second frame event.
  - A subsequent ack raises VBL_IRQ_n; IRQ_OVR stays 1.
- IRQ_ACK held high on the frame-event edge:
  - VBL_IRQ_n=0 after that edge.
  - VBL_IRQ_n=1 one edge later if IRQ_ACK remains high.
- Inject H_CNT jumping 100 -> 102:
  - COUNT_ERR=1 one cycle later and stays 1.
  - Reset clears it.
  - The first PIX_CE after reset, with H_CNT=200, does not set it.
- Toggle nRESET low at H_CNT=300, V_CNT=250 with VBL_IRQ_n low:
  - All outputs return to their reset values on that edge.
  - LB_BANK=0; LB_BANK toggles on each subsequent H_CNT=0 PIX_CE.
